// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon PIO output register between NUM_REQ requesters.
// One write strobe per grant, followed by a programmable idle gap; shadow mirrors the PIO.
module pio_write_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter int         DATA_W     = 14,
    parameter int         GAP_CYCLES = 2,
    parameter logic [1:0] PIO_ADDR   = 2'd0,
    localparam int        IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        m_chipselect,
    output logic                        m_write_n,
    output logic [1:0]                  m_address,
    output logic [31:0]                 m_writedata,
    output logic                        busy,
    output logic [IDX_W-1:0]            last_grant,
    output logic [DATA_W-1:0]           shadow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t              state_r;
    logic [3:0]          gap_cnt_r;
    logic [DATA_W-1:0]   data_a_s [NUM_REQ];
    logic [IDX_W-1:0]    idx_s;
    logic                hit_s;
    logic                grant_vld_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic [DATA_W-1:0]   grant_data_s;
    logic [NUM_REQ-1:0]  grant_onehot_s;

    // Split the packed request data bus into per-requester lanes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_a_s[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Cyclic priority search starting just after the previous winner.
    always_comb begin
        grant_vld_s  = 1'b0;
        grant_idx_s  = '0;
        grant_data_s = '0;
        idx_s        = '0;
        hit_s        = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s        = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            hit_s        = req[idx_s] & ~grant_vld_s;
            grant_idx_s  = hit_s ? idx_s : grant_idx_s;
            grant_data_s = hit_s ? data_a_s[idx_s] : grant_data_s;
            grant_vld_s  = grant_vld_s | hit_s;
        end
        grant_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end

    // Arbitration FSM; all Avalon outputs are registered so the strobe lands in WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            gap_cnt_r    <= 4'd0;
            ack          <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 2'd0;
            m_writedata  <= 32'd0;
            busy         <= 1'b0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            shadow       <= '0;
        end else begin
            ack          <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        state_r      <= ST_WRITE;
                        last_grant   <= grant_idx_s;
                        ack          <= grant_onehot_s;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= PIO_ADDR;
                        m_writedata  <= 32'(grant_data_s);
                        busy         <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        busy         <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // m_writedata holds the granted data until the next grant.
                    shadow <= m_writedata[DATA_W-1:0];
                    if (GAP_CYCLES > 0) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= GAP_LOAD;
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
